// File: rtl/svm_pkg.sv
// Shared definitions for the scaler, the frame sequencer and LinearSVC.
package svm_pkg;
    localparam int N_FEAT             = 39;
    localparam int DATA_W             = 32;
    localparam int MIN_GAP_DEF        = 2;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {FILL, GAP, BURST, WAIT} seq_state_t;
endpackage

// File: rtl/vad_hangover.sv
// Frame hangover smoothing: a speech frame keeps the decision high for
// HANGOVER further non-speech frames. A hold request re-emits the last decision.
module vad_hangover #(
    parameter int HANGOVER = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pred_valid,
    input  logic pred,
    input  logic hold,
    output logic valid,
    output logic decision
);
    localparam int CW = (HANGOVER > 0) ? $clog2(HANGOVER + 1) : 1;

    logic [CW-1:0] ho_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ho_cnt   <= '0;
            valid    <= 1'b0;
            decision <= 1'b0;
        end else begin
            valid <= pred_valid | hold;
            if (pred_valid) begin
                if (pred) begin
                    ho_cnt   <= CW'(HANGOVER);
                    decision <= 1'b1;
                end else if (ho_cnt != '0) begin
                    ho_cnt   <= ho_cnt - 1'b1;
                    decision <= 1'b1;
                end else begin
                    decision <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/svm_frame_sequencer.sv
// Captures one (possibly gapped) frame of features, replays it to LinearSVC as
// one contiguous burst, then waits for the prediction and emits a smoothed VAD decision.
module svm_frame_sequencer #(
    parameter int N_FEAT         = svm_pkg::N_FEAT,
    parameter int DATA_W         = svm_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = svm_pkg::TIMEOUT_CYCLES_DEF,
    parameter int HANGOVER       = 3,
    parameter int MIN_GAP        = svm_pkg::MIN_GAP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              svm_tvalid,
    output logic [DATA_W-1:0] svm_tdata,
    input  logic              svm_pred_valid,
    input  logic              svm_pred,
    output logic              vad_valid,
    output logic              vad_decision,
    output logic              busy,
    output logic              err_len,
    output logic              err_timeout
);
    import svm_pkg::*;

    localparam int IW      = $clog2(N_FEAT + 1);
    localparam int GW      = $clog2(MIN_GAP + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES);
    // Decided one cycle early so the registered pulse lands TIMEOUT_CYCLES
    // cycles after the last burst word.
    localparam int TO_LAST = TIMEOUT_CYCLES - 2;

    seq_state_t                     state, state_nx;
    logic [N_FEAT-1:0][DATA_W-1:0]  fbuf;
    logic [IW-1:0]                  widx, ridx;
    logic [GW-1:0]                  gap_cnt;
    logic [TW-1:0]                  to_cnt;
    logic                           drop;

    logic acc, last_slot, frame_ok, len_bad, gap_ok, burst_end, pred_fire, timeout;

    assign s_tready  = !reset && (state == FILL);
    assign busy      = !reset && (state != FILL);
    assign acc       = s_tvalid && s_tready;
    assign last_slot = (widx == IW'(N_FEAT - 1));
    assign frame_ok  = acc && !drop && s_tlast && last_slot;
    assign len_bad   = acc && !drop && (s_tlast != last_slot);
    assign gap_ok    = (gap_cnt >= GW'(MIN_GAP));
    assign burst_end = (state == BURST) && (ridx == IW'(N_FEAT));
    assign pred_fire = (state == WAIT) && svm_pred_valid;
    assign timeout   = (state == WAIT) && !svm_pred_valid && (to_cnt == TW'(TO_LAST));

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (frame_ok)              state_nx = GAP;
            GAP:     if (gap_ok)                state_nx = BURST;
            BURST:   if (burst_end)             state_nx = WAIT;
            WAIT:    if (pred_fire || timeout)  state_nx = FILL;
            default:                            state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            widx        <= '0;
            ridx        <= '0;
            drop        <= 1'b0;
            gap_cnt     <= GW'(MIN_GAP);
            to_cnt      <= '0;
            svm_tvalid  <= 1'b0;
            svm_tdata   <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            err_len     <= len_bad;
            err_timeout <= timeout;

            if (svm_tvalid)   gap_cnt <= '0;
            else if (!gap_ok) gap_cnt <= gap_cnt + 1'b1;

            // After a too-long frame, words are discarded up to and including the next s_tlast.
            if (acc) begin
                if (drop) begin
                    if (s_tlast) drop <= 1'b0;
                end else if (len_bad) begin
                    widx <= '0;
                    drop <= !s_tlast;
                end else begin
                    fbuf[widx] <= s_tdata;
                    widx       <= s_tlast ? '0 : widx + 1'b1;
                end
            end

            case (state)
                GAP: if (gap_ok) begin
                    svm_tvalid <= 1'b1;
                    svm_tdata  <= fbuf[0];
                    ridx       <= IW'(1);
                end
                BURST: if (burst_end) begin
                    svm_tvalid <= 1'b0;
                    to_cnt     <= '0;
                end else begin
                    svm_tdata  <= fbuf[ridx];
                    ridx       <= ridx + 1'b1;
                end
                WAIT:    to_cnt <= to_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    vad_hangover #(.HANGOVER(HANGOVER)) u_hangover (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_fire),
        .pred       (svm_pred),
        .hold       (timeout),
        .valid      (vad_valid),
        .decision   (vad_decision)
    );
endmodule

// File: tb/tb_svm_frame_sequencer.sv
// Self-checking bench for svm_frame_sequencer: directed frames, a hangover
// vector table, reset mid-burst, and randomized frames against a frame-level model.
module tb_svm_frame_sequencer;
    localparam int N  = 39;
    localparam int DW = 32;
    localparam int TO = 64;
    localparam int HO = 3;

    logic          clk = 1'b0, reset = 1'b1;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, svm_pred_valid = 1'b0, svm_pred = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tready, svm_tvalid, vad_valid, vad_decision, busy, err_len, err_timeout;
    logic [DW-1:0] svm_tdata;

    always #5 clk = ~clk;

    svm_frame_sequencer #(.N_FEAT(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .HANGOVER(HO), .MIN_GAP(2)) dut (
        .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(s_tready), .svm_tvalid(svm_tvalid), .svm_tdata(svm_tdata),
        .svm_pred_valid(svm_pred_valid), .svm_pred(svm_pred), .vad_valid(vad_valid),
        .vad_decision(vad_decision), .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    int nvec = 0, nerr = 0;
    int tick = 0;
    always @(posedge clk) tick++;

    // Observation of DUT outputs, sampled on the falling edge.
    logic [DW-1:0] bq[$];
    int   bursts = 0, blen = 0, run = 0, bstart = 0, blast = 0;
    logic prev_tv = 1'b0;
    int   vad_n = 0, vad_cyc = 0, elen_n = 0, eto_n = 0, eto_cyc = 0, viol = 0;
    logic vad_last = 1'b0;

    always @(negedge clk) begin
        if (svm_tvalid) begin
            if (!prev_tv) begin bstart = tick; run = 0; end
            run++;
            bq.push_back(svm_tdata);
        end else if (prev_tv) begin
            bursts++; blen = run; blast = tick - 1;
        end
        prev_tv = svm_tvalid;
        if (vad_valid) begin vad_n++; vad_cyc = tick; vad_last = vad_decision; end
        if (err_len) elen_n++;
        if (err_timeout) begin eto_n++; eto_cyc = tick; end
        if (!reset && (s_tready == busy)) viol++;
    end

    // Reference model: hangover smoothing from the decision rules.
    int m_ho = 0;
    bit m_dec = 1'b0;
    function automatic void model_pred(input bit p);
        if (p) begin m_ho = HO; m_dec = 1'b1; end
        else if (m_ho > 0) begin m_ho--; m_dec = 1'b1; end
        else m_dec = 1'b0;
    endfunction

    function automatic logic [31:0] fbits(input int v);
        int e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(e + 127), 23'((v - (1 << e)) << (23 - e))};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    logic [DW-1:0] fr [64];

    task automatic send_frame(input int len, input int gap, input bit fl, output int tl);
        tl = 0;
        for (int i = 0; i < len; i++) begin
            int  w;
            bit  ok;
            fr[i] = fl ? fbits(i + 1) : $urandom;
            while (gap > 0 && $urandom_range(99) < gap) begin s_tvalid = 1'b0; step(1); end
            s_tvalid = 1'b1; s_tdata = fr[i]; s_tlast = (i == len - 1);
            w = 0;
            do begin ok = s_tready; tl = tick; step(1); w++; end while (!ok && w < 300);
            if (!ok) chk("accept_bound", 0, 1);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    // mode: 0/1 = prediction value, 2 = prediction withheld; dly = cycles after last burst word
    task automatic run_frame(input int len, input int gap, input bit fl, input int mode, input int dly);
        int tl, b0, bn, e0, v0, t0, w, p;
        b0 = bq.size(); bn = bursts; e0 = elen_n; v0 = vad_n; t0 = eto_n;
        send_frame(len, gap, fl, tl);
        if (len != N) begin
            step(4);
            chk("err_len_pulse", elen_n - e0, 1);
            chk("no_burst_on_bad", bq.size() - b0, 0);
            chk("idle_after_bad", busy, 0);
            return;
        end
        w = 0;
        while (bursts == bn && w < 200) begin step(1); w++; end
        chk("burst_seen", bursts - bn, 1);
        if (bursts == bn) return;
        chk("burst_start", bstart - tl, 2);
        chk("burst_len", blen, N);
        if (bq.size() - b0 >= N)
            for (int i = 0; i < N; i++) chk("burst_data", bq[b0 + i], fr[i]);
        chk("err_len_none", elen_n - e0, 0);
        if (mode < 2) begin
            while (tick < blast + dly) step(1);
            p = tick; svm_pred_valid = 1'b1; svm_pred = mode[0];
            step(1); svm_pred_valid = 1'b0; step(2);
            model_pred(mode[0]);
            chk("vad_pulse", vad_n - v0, 1);
            chk("vad_cycle", vad_cyc - p, 1);
            chk("vad_decision", vad_last, m_dec);
            chk("no_timeout", eto_n - t0, 0);
        end else begin
            w = 0;
            while (eto_n == t0 && w < 150) begin step(1); w++; end
            step(1);
            chk("timeout_seen", eto_n - t0, 1);
            chk("timeout_cycle", eto_cyc - blast, TO);
            chk("timeout_vad", vad_n - v0, 1);
            chk("timeout_hold", vad_last, m_dec);
        end
        step(1);
        chk("back_to_fill", s_tready, 1);
    endtask

    typedef struct packed { bit pred; bit dec; } hv_t;
    hv_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got stuck expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int tl, v0, s, w;
        tbl[0] = '{1'b1, 1'b1}; tbl[1] = '{1'b0, 1'b1}; tbl[2] = '{1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1}; tbl[4] = '{1'b0, 1'b0}; tbl[5] = '{1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1}; tbl[7] = '{1'b0, 1'b1}; tbl[8] = '{1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0};

        reset = 1'b1; step(3);
        chk("rst_tready", s_tready, 0);      chk("rst_busy", busy, 0);
        chk("rst_svm_tvalid", svm_tvalid, 0); chk("rst_vad_valid", vad_valid, 0);
        chk("rst_decision", vad_decision, 0); chk("rst_err_len", err_len, 0);
        chk("rst_err_timeout", err_timeout, 0);
        reset = 1'b0; step(1);
        chk("tready_after_reset", s_tready, 1);

        run_frame(N, 0, 1'b1, 1, 20);          // contiguous 1.0..39.0, speech
        run_frame(N, 50, 1'b0, 0, 10);         // gapped upstream
        run_frame(20, 0, 1'b0, 1, 10);         // short frame
        run_frame(N, 0, 1'b0, 1, 10);
        run_frame(40, 0, 1'b0, 1, 10);         // long frame, realign on tlast
        run_frame(N, 30, 1'b0, 1, 10);

        for (int i = 0; i < 10; i++) begin
            run_frame(N, 0, 1'b0, int'(tbl[i].pred), 8);
            chk("hangover_table", vad_last, tbl[i].dec);
        end

        run_frame(N, 0, 1'b0, 1, 12);
        run_frame(N, 0, 1'b0, 2, 0);           // withheld prediction
        run_frame(N, 0, 1'b0, 0, 63);          // prediction coincides with timeout

        // Reset on the 10th burst cycle
        v0 = vad_n;
        send_frame(N, 0, 1'b0, tl);
        w = 0;
        while (!svm_tvalid && w < 20) begin step(1); w++; end
        chk("burst_before_reset", svm_tvalid, 1);
        s = tick;
        step(9);
        reset = 1'b1; #1;
        chk("midrst_tready", s_tready, 0);
        chk("midrst_busy", busy, 0);
        step(1); reset = 1'b0;
        chk("midrst_cycle", tick - s, 10);
        chk("midrst_svm_tvalid", svm_tvalid, 0);
        chk("midrst_vad_valid", vad_valid, 0);
        chk("midrst_decision", vad_decision, 0);
        chk("midrst_err", {err_len, err_timeout}, 0);
        chk("midrst_busy_after", busy, 0);
        m_ho = 0; m_dec = 1'b0;
        svm_pred_valid = 1'b1; svm_pred = 1'b1; step(1); svm_pred_valid = 1'b0; step(3);
        chk("late_pred_ignored", vad_n - v0, 0);
        run_frame(N, 0, 1'b0, 0, 15);

        repeat (20) begin
            int len, md;
            len = N;
            if ($urandom_range(9) < 2) begin
                len = $urandom_range(1, 45);
                if (len == N) len = N + 1;
            end
            md = ($urandom_range(9) == 0) ? 2 : int'($urandom_range(1));
            run_frame(len, ($urandom_range(1) == 1) ? 50 : 0, 1'b0, md, $urandom_range(3, 63));
        end

        chk("tready_busy_exclusive", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
